// File: rtl/output_fill_ctrl_pkg.sv
// Shared definitions for the output feature-map write sequencer.
//   DEF_ADDR_W : default RAM word-address width
//   DEF_SIZE_W : default map side-length width (word counts use twice this)
//   state_e    : sequencer states
package output_fill_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_SIZE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/output_fill_ctrl_counter.sv
// Loadable up-counter with terminal-count compare.
//   clk, rst  : clock, async active-high reset
//   clr_i     : synchronous clear to zero (wins over inc_i)
//   inc_i     : increment by one
//   limit_i   : terminal value
//   count_o   : registered count
//   tc_c      : combinational, high when count_o == limit_i
module output_fill_ctrl_counter
  import output_fill_ctrl_pkg::*;
#(
  parameter int unsigned W = 2 * DEF_SIZE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         tc_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_c    = (count_q == limit_i);

endmodule

// File: rtl/output_fill_ctrl.sv
// Write-side address sequencer for the output feature-map RAM. Pops one
// result per available FIFO entry and writes it one cycle later at
// base + word index, covering N*N words, then reports done.
//   w_clk, reset          : clock, async active-high reset
//   enable                : level start/run request
//   initial_address       : base RAM address, sampled at start
//   output_featuremapsize : map side N, sampled at start
//   is_empty              : result FIFO empty flag
//   c_address             : RAM write address (valid with write_enable)
//   write_enable          : RAM write strobe
//   read_enable           : FIFO pop strobe
//   done                  : fill complete
module output_fill_ctrl
  import output_fill_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned SIZE_W = DEF_SIZE_W
) (
  input  logic              w_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] initial_address,
  input  logic [SIZE_W-1:0] output_featuremapsize,
  input  logic              is_empty,
  output logic [ADDR_W-1:0] c_address,
  output logic              write_enable,
  output logic              read_enable,
  output logic              done
);

  localparam int unsigned CNT_W = 2 * SIZE_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [ADDR_W-1:0] c_address_q, c_address_d;
  logic              write_enable_q, write_enable_d;
  logic              read_enable_q, read_enable_d;
  logic              done_q, done_d;

  logic              cnt_clr;
  logic              issue_inc;
  logic              write_inc;
  logic [CNT_W-1:0]  issued_cnt;
  logic [CNT_W-1:0]  written_cnt;
  logic              issued_tc;
  logic              written_tc;

  // Pops issued to the FIFO
  output_fill_ctrl_counter #(.W(CNT_W)) u_issued (
    .clk     (w_clk),
    .rst     (reset),
    .clr_i   (cnt_clr),
    .inc_i   (issue_inc),
    .limit_i (total_q),
    .count_o (issued_cnt),
    .tc_c    (issued_tc)
  );

  // Words written to the RAM
  output_fill_ctrl_counter #(.W(CNT_W)) u_written (
    .clk     (w_clk),
    .rst     (reset),
    .clr_i   (cnt_clr),
    .inc_i   (write_inc),
    .limit_i (total_q),
    .count_o (written_cnt),
    .tc_c    (written_tc)
  );

  // Next-state and output logic
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    total_d        = total_q;
    c_address_d    = c_address_q;
    write_enable_d = 1'b0;
    read_enable_d  = 1'b0;
    done_d         = 1'b0;
    cnt_clr        = 1'b0;
    issue_inc      = 1'b0;
    write_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          base_d  = initial_address;
          total_d = CNT_W'(output_featuremapsize) * CNT_W'(output_featuremapsize);
          cnt_clr = 1'b1;
          if (output_featuremapsize == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        // Pop only while data is available, the run is enabled and words remain
        read_enable_d = !is_empty && enable && (issued_cnt < total_q);
        issue_inc     = read_enable_d;
        // FIFO data lands one cycle after the pop; address wraps modulo 2^ADDR_W
        write_enable_d = read_enable_q;
        if (read_enable_q) begin
          c_address_d = base_q + ADDR_W'(written_cnt);
          write_inc   = 1'b1;
        end
        // Complete once every popped word has been written
        if (written_tc && issued_tc) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        done_d = 1'b1;
        if (!enable) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      base_q         <= '0;
      total_q        <= '0;
      c_address_q    <= '0;
      write_enable_q <= 1'b0;
      read_enable_q  <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      total_q        <= total_d;
      c_address_q    <= c_address_d;
      write_enable_q <= write_enable_d;
      read_enable_q  <= read_enable_d;
      done_q         <= done_d;
    end
  end

  assign c_address    = c_address_q;
  assign write_enable = write_enable_q;
  assign read_enable  = read_enable_q;
  assign done         = done_q;

endmodule

// File: tb/tb_output_fill_ctrl.sv
// Directed self-checking bench for output_fill_ctrl.
module tb_output_fill_ctrl;

  logic       w_clk;
  logic       reset;
  logic       enable;
  logic [9:0] initial_address;
  logic [7:0] output_featuremapsize;
  logic       is_empty;
  logic [9:0] c_address;
  logic       write_enable;
  logic       read_enable;
  logic       done;

  output_fill_ctrl dut (
    .w_clk                 (w_clk),
    .reset                 (reset),
    .enable                (enable),
    .initial_address       (initial_address),
    .output_featuremapsize (output_featuremapsize),
    .is_empty              (is_empty),
    .c_address             (c_address),
    .write_enable          (write_enable),
    .read_enable           (read_enable),
    .done                  (done)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_wr;
  int         n_rd;
  int         cyc = 0;
  int         first_wr;
  int         last_wr;
  logic       prev_rd;
  logic [9:0] exp_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_track(input logic [9:0] base);
    n_wr     = 0;
    n_rd     = 0;
    first_wr = 0;
    last_wr  = 0;
    prev_rd  = 1'b0;
    exp_addr = base;
  endtask

  // One clock: sample #1 after the edge and check every write/pop seen
  task automatic tick();
    logic empty_at_edge;
    logic en_at_edge;
    empty_at_edge = is_empty;
    en_at_edge    = enable;
    @(posedge w_clk);
    #1;
    cyc++;
    if (write_enable) begin
      chk("wr_addr", 32'(c_address), 32'(exp_addr));
      chk("rd_leads_wr", 32'(prev_rd), 32'd1);
      chk("done_during_wr", 32'(done), 32'd0);
      if (n_wr == 0) first_wr = cyc;
      last_wr  = cyc;
      exp_addr = exp_addr + 10'd1;
      n_wr++;
    end
    if (read_enable) begin
      chk("pop_gate", 32'({empty_at_edge, en_at_edge}), 32'b01);
      n_rd++;
    end
    prev_rd = read_enable;
  endtask

  task automatic run_to_done(input string tag);
    int g;
    g = 0;
    while (!done && g < 400) begin
      tick();
      g++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic stop_run();
    enable = 1'b0;
    tick();
    tick();
    chk("back_to_idle", 32'({done, read_enable, write_enable}), 32'd0);
  endtask

  initial begin
    reset                 = 1'b1;
    enable                = 1'b0;
    initial_address       = 10'h000;
    output_featuremapsize = 8'd0;
    is_empty              = 1'b1;
    #1;
    chk("reset_addr", 32'(c_address), 32'd0);
    chk("reset_flags", 32'({done, read_enable, write_enable}), 32'd0);
    @(negedge w_clk);
    reset = 1'b0;

    // 1: full-rate fill of an 8x8 map
    initial_address       = 10'h010;
    output_featuremapsize = 8'd8;
    is_empty              = 1'b0;
    clear_track(10'h010);
    enable = 1'b1;
    run_to_done("t1_done");
    chk("t1_writes", 32'(n_wr), 32'd64);
    chk("t1_pops", 32'(n_rd), 32'd64);
    chk("t1_span", 32'(last_wr - first_wr), 32'd63);
    chk("t1_last_addr", 32'(c_address), 32'h04F);
    chk("t1_done_quiet", 32'({read_enable, write_enable}), 32'd0);
    tick();
    chk("t1_done_hold", 32'({done, 10'(c_address)}), 32'({1'b1, 10'h04F}));
    stop_run();

    // 2: FIFO empty toggling every 3 cycles
    clear_track(10'h010);
    enable = 1'b1;
    for (int g = 0; g < 400 && !done; g++) begin
      is_empty = ((g / 3) % 2) == 1;
      tick();
    end
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_writes", 32'(n_wr), 32'd64);
    chk("t2_pops", 32'(n_rd), 32'd64);
    chk("t2_last_addr", 32'(c_address), 32'h04F);
    is_empty = 1'b0;
    stop_run();

    // 3: zero-size map completes immediately
    output_featuremapsize = 8'd0;
    clear_track(10'h010);
    enable = 1'b1;
    tick();
    chk("t3_done", 32'(done), 32'd1);
    tick();
    tick();
    chk("t3_writes", 32'(n_wr), 32'd0);
    chk("t3_pops", 32'(n_rd), 32'd0);
    stop_run();

    // 4: pause after 20 writes, resume at base+21
    output_featuremapsize = 8'd8;
    clear_track(10'h010);
    enable = 1'b1;
    for (int g = 0; g < 100 && n_wr < 20; g++) tick();
    chk("t4_at20", 32'(n_wr), 32'd20);
    enable = 1'b0;
    for (int g = 0; g < 5; g++) tick();
    chk("t4_inflight", 32'(n_wr), 32'd21);
    chk("t4_pops_held", 32'(n_rd), 32'd21);
    chk("t4_paused", 32'({read_enable, write_enable}), 32'd0);
    chk("t4_addr_hold", 32'(c_address), 32'h024);
    enable = 1'b1;
    run_to_done("t4_done");
    chk("t4_writes", 32'(n_wr), 32'd64);
    chk("t4_pops", 32'(n_rd), 32'd64);
    chk("t4_last_addr", 32'(c_address), 32'h04F);
    stop_run();

    // 5: async reset at word 30, then rerun from the base
    clear_track(10'h010);
    enable = 1'b1;
    for (int g = 0; g < 100 && n_wr < 30; g++) tick();
    chk("t5_at30", 32'(n_wr), 32'd30);
    chk("t5_busy", 32'({read_enable, write_enable}), 32'b11);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_addr", 32'(c_address), 32'd0);
    chk("t5_async_flags", 32'({done, read_enable, write_enable}), 32'd0);
    @(negedge w_clk);
    reset = 1'b0;
    clear_track(10'h010);
    run_to_done("t5_done");
    chk("t5_writes", 32'(n_wr), 32'd64);
    chk("t5_last_addr", 32'(c_address), 32'h04F);
    stop_run();

    // 6: address wrap past the top of the RAM
    initial_address       = 10'h3FC;
    output_featuremapsize = 8'd3;
    clear_track(10'h3FC);
    enable = 1'b1;
    run_to_done("t6_done");
    chk("t6_writes", 32'(n_wr), 32'd9);
    chk("t6_pops", 32'(n_rd), 32'd9);
    chk("t6_last_addr", 32'(c_address), 32'h004);
    stop_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
